// File: rtl/ledpi_pkg.sv
// Shared constants, command codes and command FSM state type for the
// LED-matrix SPI frame loader.
package ledpi_pkg;
  localparam int ROWS        = 32;
  localparam int COLS        = 64;
  localparam int FRAME_BYTES = ROWS * COLS * 3;
  localparam int ADDR_W      = 13;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_SWAP  = 8'h02;

  localparam logic [3:0] STATUS_SIG = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/spi_frame_loader_if.sv
// SPI pins, framebuffer write port and scanner swap handshake of the loader.
interface spi_frame_loader_if #(
  parameter int ADDR_W = ledpi_pkg::ADDR_W
);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              fb_we;
  logic              fb_buf;
  logic [ADDR_W-1:0] fb_waddr;
  logic [7:0]        fb_wdata;
  logic              front_buf;
  logic              swap_req;
  logic              swap_ack;
  logic              frame_done;

  modport master (
    input  sck, cs_n, mosi, swap_ack,
    output miso, fb_we, fb_buf, fb_waddr, fb_wdata, front_buf, swap_req, frame_done
  );

  modport slave (
    output sck, cs_n, mosi, swap_ack,
    input  miso, fb_we, fb_buf, fb_waddr, fb_wdata, front_buf, swap_req, frame_done
  );
endinterface

// File: rtl/spi_byte_rx.sv
// Mode-0 SPI slave byte engine: pin synchronizers, edge detect, RX byte
// assembly and MISO status shift-out, all in the clk domain.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic [7:0] status,
  output logic       miso,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       cs_start,
  output logic       cs_end,
  output logic       status_done
);
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic [6:0] rx_sh;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sh;
  logic [3:0] tx_cnt;
  logic       sck_rise;
  logic       sck_fall;
  logic       cs_fall;
  logic       cs_act;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_act   = ~cs_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q       <= '0;
      cs_q        <= '0;
      mosi_q      <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      tx_cnt      <= 4'd8;
      miso        <= 1'b0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      cs_start    <= 1'b0;
      cs_end      <= 1'b0;
      status_done <= 1'b0;
    end else begin
      sck_q       <= {sck_q[1:0], sck};
      cs_q        <= {cs_q[1:0], cs_n};
      mosi_q      <= {mosi_q[0], mosi};
      byte_valid  <= 1'b0;
      status_done <= 1'b0;
      cs_start    <= cs_fall;
      cs_end      <= ~cs_act;
      if (!cs_act) begin
        // partial bytes die here; tx_cnt=8 keeps miso quiet
        bit_cnt <= '0;
        tx_cnt  <= 4'd8;
        miso    <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sh   <= {rx_sh[5:0], mosi_q[1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            byte_data  <= {rx_sh, mosi_q[1]};
          end
        end
        if (cs_fall) begin
          tx_sh  <= status[6:0];
          tx_cnt <= 4'd0;
          miso   <= status[7];
        end else if (sck_fall && tx_cnt < 4'd8) begin
          tx_sh       <= {tx_sh[5:0], 1'b0};
          tx_cnt      <= tx_cnt + 4'd1;
          miso        <= (tx_cnt == 4'd7) ? 1'b0 : tx_sh[6];
          status_done <= (tx_cnt == 4'd7);
        end
      end
    end
  end
endmodule

// File: rtl/spi_frame_loader.sv
// Command FSM, back-buffer address counter, sticky errors and swap handshake
// on top of the SPI byte engine.
//  state    | meaning
//  ST_IDLE  | no transaction, waiting for CS fall
//  ST_CMD   | next byte is the command
//  ST_WRITE | pixel bytes go to the back buffer
//  ST_DRAIN | bytes ignored until CS rises
module spi_frame_loader #(
  parameter int ROWS        = ledpi_pkg::ROWS,
  parameter int COLS        = ledpi_pkg::COLS,
  parameter int FRAME_BYTES = ROWS * COLS * 3,
  parameter int ADDR_W      = ledpi_pkg::ADDR_W
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_frame_loader_if.master  bus
);
  import ledpi_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              err_ovf, err_busy;
  logic              ovf_rd, busy_rd;
  logic              front_q, fb_buf_q, swap_req_q;
  logic              fb_we_q, frame_done_q;
  logic [ADDR_W-1:0] fb_waddr_q;
  logic [7:0]        fb_wdata_q;
  logic              byte_valid, cs_start, cs_end, status_done;
  logic [7:0]        byte_data;
  logic [7:0]        status;
  logic              req_kept, cmd_byte, swap_cmd, busy_set, ovf_set, addr_full;

  assign status = {front_q, swap_req_q, err_ovf, err_busy, STATUS_SIG};

  spi_byte_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck         (bus.sck),
    .cs_n        (bus.cs_n),
    .mosi        (bus.mosi),
    .status      (status),
    .miso        (bus.miso),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .cs_start    (cs_start),
    .cs_end      (cs_end),
    .status_done (status_done)
  );

  // an ack is serviced before a same-cycle SWAP or WRITE command is judged
  assign req_kept  = swap_req_q & ~bus.swap_ack;
  assign cmd_byte  = byte_valid & ~cs_end & (state == ST_CMD);
  assign swap_cmd  = cmd_byte & (byte_data == CMD_SWAP);
  assign busy_set  = cmd_byte & (byte_data == CMD_WRITE) & req_kept;
  assign addr_full = (addr == ADDR_W'(FRAME_BYTES));
  assign ovf_set   = byte_valid & ~cs_end & (state == ST_WRITE) & addr_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr         <= '0;
      err_ovf      <= 1'b0;
      err_busy     <= 1'b0;
      ovf_rd       <= 1'b0;
      busy_rd      <= 1'b0;
      front_q      <= 1'b0;
      fb_buf_q     <= 1'b1;
      swap_req_q   <= 1'b0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= '0;
    end else begin
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      swap_req_q   <= req_kept | swap_cmd;
      if (bus.swap_ack && swap_req_q) begin
        front_q  <= ~front_q;
        fb_buf_q <= front_q;
      end
      if (cs_start) begin
        ovf_rd  <= err_ovf;
        busy_rd <= err_busy;
      end
      // read-to-clear only drops the flags the host was actually shown
      err_ovf  <= ovf_set  | (err_ovf  & ~(status_done & ovf_rd));
      err_busy <= busy_set | (err_busy & ~(status_done & busy_rd));
      if (cs_end) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (cs_start) state <= ST_CMD;
          ST_CMD: begin
            if (byte_valid) begin
              if (byte_data == CMD_WRITE && !req_kept) begin
                state <= ST_WRITE;
                addr  <= '0;
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
          ST_WRITE: begin
            if (byte_valid && !addr_full) begin
              fb_we_q      <= 1'b1;
              fb_waddr_q   <= addr;
              fb_wdata_q   <= byte_data;
              frame_done_q <= (addr == ADDR_W'(FRAME_BYTES - 1));
              addr         <= addr + 1'b1;
            end
          end
          ST_DRAIN: state <= ST_DRAIN;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_buf     = fb_buf_q;
  assign bus.fb_waddr   = fb_waddr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.front_buf  = front_q;
  assign bus.swap_req   = swap_req_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed-plus-random bench for spi_frame_loader with a transaction-level
// reference model and a write-port monitor.
module tb_spi_frame_loader;
  localparam int R  = 4;
  localparam int C  = 16;
  localparam int FB = R * C * 3;

  typedef struct {
    logic       bufi;
    int         addr;
    logic [7:0] data;
    logic       done;
    int         idx;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  wr_t        exp_q[$];
  int         rise_cyc[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_status;
  logic       m_front, m_req, m_ovf, m_busy;
  logic [7:0] m_status;

  spi_frame_loader_if #(.ADDR_W(13)) bus ();

  spi_frame_loader #(.ROWS(R), .COLS(C), .ADDR_W(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fb_we === 1'b1) begin
      chk("we_expected", 16'(exp_q.size() > 0), 16'd1);
      if (exp_q.size() > 0) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("fb_waddr", bus.fb_waddr, 16'(w.addr));
        chk("fb_wdata", bus.fb_wdata, w.data);
        chk("fb_buf", bus.fb_buf, w.bufi);
        chk("frame_done", bus.frame_done, w.done);
        if (w.idx < rise_cyc.size())
          chk("we_latency", 16'(cyc - rise_cyc[w.idx]), 16'd4);
      end
    end else if (bus.frame_done === 1'b1) begin
      chk("done_without_we", bus.frame_done, 16'd0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_front = 1'b0; m_req = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  // whole-transaction effect: status snapshot at CS fall, command, shown
  // errors cleared after the 8th status bit, then pixel bytes
  task automatic model_txn(input int nbits);
    int   nb, a;
    logic sh_o, sh_b, write_ok;
    nb = nbits / 8;
    m_status = {m_front, m_req, m_ovf, m_busy, 4'h5};
    sh_o = m_ovf;
    sh_b = m_busy;
    if (nb >= 1) begin
      write_ok = (tx_q[0] == 8'h01) && !m_req;
      if (tx_q[0] == 8'h01 && m_req) m_busy = 1'b1;
      if (tx_q[0] == 8'h02) m_req = 1'b1;
      m_ovf  = m_ovf & !sh_o;
      m_busy = m_busy & !sh_b;
      if (write_ok) begin
        a = 0;
        for (int k = 1; k < nb; k++) begin
          if (a < FB) begin
            exp_q.push_back('{bufi: !m_front, addr: a, data: tx_q[k], done: (a == FB - 1), idx: k});
            a++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, bus.miso, 16'd0);
    chk({tag, "_fb_we"}, bus.fb_we, 16'd0);
    chk({tag, "_fb_buf"}, bus.fb_buf, 16'd1);
    chk({tag, "_fb_waddr"}, bus.fb_waddr, 16'd0);
    chk({tag, "_fb_wdata"}, bus.fb_wdata, 16'd0);
    chk({tag, "_front_buf"}, bus.front_buf, 16'd0);
    chk({tag, "_swap_req"}, bus.swap_req, 16'd0);
    chk({tag, "_frame_done"}, bus.frame_done, 16'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    wait_cyc(3);
    check_reset_outputs(tag);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, "_front_buf"}, bus.front_buf, m_front);
    chk({tag, "_fb_buf"}, bus.fb_buf, !m_front);
    chk({tag, "_swap_req"}, bus.swap_req, m_req);
  endtask

  task automatic do_ack();
    swap_ack_drive(1'b1);
    swap_ack_drive(1'b0);
    if (m_req) begin
      m_front = !m_front;
      m_req   = 1'b0;
    end
  endtask

  task automatic swap_ack_drive(input logic v);
    bus.swap_ack = v;
    wait_cyc(1);
  endtask

  // sck half period of 5 clk; rst_at > 0 pulses rst_n after that many bytes
  task automatic spi_txn(input int nbits, input int rst_at);
    rise_cyc.delete();
    rx_status = '0;
    bus.cs_n = 1'b0;
    wait_cyc(5);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx_q[i / 8][7 - (i % 8)];
      wait_cyc(5);
      bus.sck = 1'b1;
      if (i < 8) rx_status[7 - i] = bus.miso;
      if (i % 8 == 7) rise_cyc.push_back(cyc);
      wait_cyc(5);
      bus.sck = 1'b0;
      if (rst_at > 0 && i == rst_at * 8 - 1) begin
        wait_cyc(5);
        do_reset("midrst");
      end
    end
    wait_cyc(5);
    bus.cs_n = 1'b1;
    wait_cyc(10);
  endtask

  task automatic run_txn(input string tag, input int nbits);
    model_txn(nbits);
    spi_txn(nbits, 0);
    chk({tag, "_status"}, rx_status, m_status);
    check_ctrl(tag);
  endtask

  initial begin
    int n;
    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.swap_ack = 1'b0;
    wait_cyc(2);
    do_reset("reset");
    wait_cyc(5);

    tx_q = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run_txn("write6", 7 * 8);

    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(20, 1);
      tx_q = '{8'h01};
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      run_txn("rand_write", (n + 1) * 8);
    end

    tx_q = '{8'h01};
    for (int k = 0; k < FB + 2; k++) tx_q.push_back(8'($urandom));
    run_txn("full_frame", (FB + 3) * 8);
    tx_q = '{8'h00};
    run_txn("ovf_read", 8);
    chk("ovf_status_value", rx_status, 16'h25);
    run_txn("ovf_cleared", 8);

    do_ack();
    check_ctrl("ack_idle");
    tx_q = '{8'h02};
    run_txn("swap", 8);
    wait_cyc(10);
    do_ack();
    check_ctrl("swap_ack");
    tx_q = '{8'h00};
    run_txn("swap_status", 8);
    chk("swap_status_value", rx_status, 16'h85);

    tx_q = '{8'h01, 8'hA5};
    run_txn("partial", 13);
    tx_q = '{8'h01, 8'h3C, 8'hC3, 8'h5A};
    run_txn("after_partial", 4 * 8);

    do_reset("reset2");
    wait_cyc(5);
    tx_q = '{8'h02};
    run_txn("swap2", 8);
    tx_q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    run_txn("busy_write", 5 * 8);
    tx_q = '{8'h00};
    run_txn("busy_status", 8);
    chk("busy_status_value", rx_status, 16'h55);
    do_ack();
    check_ctrl("busy_ack");

    tx_q = '{8'h01};
    for (int k = 0; k < 104; k++) tx_q.push_back(8'($urandom));
    model_txn(101 * 8);
    spi_txn(105 * 8, 101);
    check_ctrl("after_midrst");
    tx_q = '{8'h01, 8'hEE, 8'h77};
    run_txn("post_rst_write", 3 * 8);

    wait_cyc(10);
    chk("exp_q_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_loader.md
# spi_frame_loader

Upstream stage of the LED-matrix scanner. A mode-0 SPI slave receives byte-framed commands from the host and writes RGB pixel bytes into the back half of a double-buffered framebuffer. On host request it hands a buffer swap to the scanner with a req/ack handshake. It also returns a status byte on MISO.

## Interface
Parameters:
- ROWS, 32, panel rows
- COLS, 64, panel columns
- FRAME_BYTES, ROWS*COLS*3 (6144), pixel bytes per frame
- ADDR_W, 13, framebuffer byte-address width; must satisfy 2^ADDR_W ≥ FRAME_BYTES

Ports:
- clk  in  1  system clock (internal oscillator domain)
- rst_n  in  1  synchronous reset, active-low
- sck  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active-low, asynchronous
- mosi  in  1  SPI data in, asynchronous
- miso  out  1  SPI data out
- fb_we  out  1  one-cycle framebuffer write strobe
- fb_buf  out  1  buffer index for the write (always !front_buf)
- fb_waddr  out  ADDR_W  byte address: (row*COLS+col)*3 + channel, with channel order R,G,B
- fb_wdata  out  8  pixel byte
- front_buf  out  1  buffer the scanner displays
- swap_req  out  1  swap pending; scanner must act on it at its next frame boundary
- swap_ack  in  1  one-cycle pulse from scanner; swap is taken
- frame_done  out  1  one-cycle pulse when byte FRAME_BYTES-1 is written

## Operation
- Input sync: sck, cs_n and mosi each pass through 2 flops. Edges are detected from the synchronized value and a 3rd flop.
- Transaction: begins when synchronized cs_n falls. Ends when it rises, or in any cycle where cs_n is high.
- Byte framing: mosi is sampled MSB first on sck rising edges. A byte completes on the 8th rising edge. A partial byte at CS rise is discarded.
- Command FSM states:
  - IDLE
  - CMD: first byte of transaction
  - WRITE: after 0x01
  - DRAIN: any other byte; bytes are ignored until CS rises
- Commands:
  - 0x01 WRITE: back-buffer address resets to 0; each following byte is written at the current address, then the address increments.
  - 0x02 SWAP: if swap_req=0, set swap_req=1; else ignore. Then DRAIN.
  - 0x00 NOP: go to DRAIN.
  - Any other byte: go to DRAIN.
- WRITE boundaries:
  - The byte at address FRAME_BYTES-1 is written and frame_done pulses.
  - Later bytes are dropped, no write occurs, and sticky err_ovf is set. The address never wraps.
- Busy rule: a WRITE command while swap_req=1 sets sticky err_busy. All of its bytes are dropped (DRAIN), which protects the buffer about to be displayed.
- Swap handshake:
  - swap_ack with swap_req=1: front_buf toggles and swap_req clears in the same edge.
  - swap_ack with swap_req=0: ignored.
  - swap_ack arriving in the same cycle as a new SWAP command byte: the ack is serviced first and the new request is then set. swap_req stays 1 and front_buf toggles once.
- MISO status byte: {front_buf, swap_req, err_ovf, err_busy, 4'h5}.
  - Captured at CS fall and shifted MSB first; bit 7 is driven before the first sck rise.
  - Shifts on each sck falling edge.
  - After 8 bits, miso=0 for the rest of the transaction. miso=0 while CS is high.
- Error clear: err_ovf and err_busy clear when the 8th status bit has been shifted (read-to-clear). An error raised in the same cycle wins and stays set.

## Timing
- Reset values: miso=0, fb_we=0, fb_buf=1, fb_waddr=0, fb_wdata=0, front_buf=0, swap_req=0, frame_done=0.
- Reset also sets the FSM to IDLE and clears bit count, errors and sync flops.
- Reset mid-transaction aborts it. The FSM stays in IDLE until the next synchronized CS fall.
- Write latency: fb_we asserts exactly 4 clk cycles after the sck pin rise that samples bit 0 (LSB) of a pixel byte. That is 2 sync cycles, 1 edge-detect cycle and 1 register cycle.
- frame_done is coincident with the last fb_we.
- swap_req rises 4 cycles after the rise sampling the LSB of the 0x02 byte.
- front_buf and fb_buf change the cycle after swap_ack.
- Host constraints: sck high/low ≥ 4 clk periods each (sck ≤ clk/8); CS setup and hold ≥ 4 clk periods around sck edges.
- Write strobes are never closer together than 32 clk cycles.

## Structure
- Package ledpi_pkg: ROWS, COLS, FRAME_BYTES, ADDR_W, the command codes CMD_NOP/CMD_WRITE/CMD_SWAP, STATUS_SIG=4'h5, and the FSM state enum.
- Sub-module spi_byte_rx:
  - Owns the synchronizers, edge detect, RX shift register and bit counter, and the MISO shift-out.
  - Outputs: byte_valid pulse, byte_data, cs_start, cs_end.
- Top level holds the command FSM, address counter, error flags and swap handshake.

## Test plan
- Reset then WRITE 0x01 followed by 6 bytes 0x10..0x15: fb_we pulses at addresses 0..5 with data 0x10..0x15, fb_buf=1, latency 4 cycles each, no frame_done.
- Full frame of 6144 bytes then 2 extra: the last write is at address 6143 with frame_done=1; extra bytes produce no fb_we. The next transaction reads status 0x25; the one after reads 0x05.
- SWAP 0x02, then scanner swap_ack 10 cycles later: swap_req 1→0, front_buf 0→1, fb_buf 1→0. A status read returns 0x85.
- SWAP then WRITE before ack: WRITE produces no fb_we, and status reads 0x55 (swap_req=1, err_busy=1).
- CS raised after 5 bits of a pixel byte: no write. The next WRITE restarts at address 0.
- rst_n asserted mid-WRITE at address 100: all outputs return to reset values. The next WRITE begins at address 0.
